// File: rtl/discharge_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : discharge_sequencer_if
// Brief    : Command/config inputs and gate-drive/status outputs of the EDM
//            discharge pulse sequencer, bundled as one interface.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface discharge_sequencer_if;
  // Configuration from the SPI register block
  logic [15:0] cfg_ton_us;
  logic [15:0] cfg_toff_us;
  logic        cfg_single;
  // Commands and sensing
  logic        machine_start;
  logic        machine_stop;
  logic        single_req;
  logic        is_breakdown;
  // Gate drives and status
  logic        pulse_on;
  logic        deion_on;
  logic        operation_indicator;
  logic        will_single_discharge_indicator;
  logic        open_circuit;
  logic        cycle_done;
  logic [15:0] discharge_cnt;
  logic [2:0]  state;

  // Controller side (drives commands, observes status)
  modport master (
    output cfg_ton_us, cfg_toff_us, cfg_single,
    output machine_start, machine_stop, single_req, is_breakdown,
    input  pulse_on, deion_on, operation_indicator,
    input  will_single_discharge_indicator, open_circuit, cycle_done,
    input  discharge_cnt, state
  );

  // Sequencer side
  modport slave (
    input  cfg_ton_us, cfg_toff_us, cfg_single,
    input  machine_start, machine_stop, single_req, is_breakdown,
    output pulse_on, deion_on, operation_indicator,
    output will_single_discharge_indicator, open_circuit, cycle_done,
    output discharge_cnt, state
  );
endinterface

`default_nettype wire

// File: rtl/discharge_sequencer.sv
//------------------------------------------------------------------------------
// Module   : discharge_sequencer
// Brief    : EDM pulse-cycle controller. Sequences gap-on, breakdown wait,
//            Ton discharge, dead time and Toff deionisation.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module discharge_sequencer #(
  parameter int CLK_PER_US      = 50,
  parameter int DEAD_TIME       = 10,   // must not exceed CLK_PER_US
  parameter int WAIT_TIMEOUT_US = 1000
) (
  input  wire logic             clk_in,
  input  wire logic             sys_rst_n,
  discharge_sequencer_if.slave  bus
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  // Dead time is timed on the prescaler alone, so it fits in one microsecond
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_PER_US - 1);
  localparam logic [PRE_W-1:0] DEAD_LAST = PRE_W'(DEAD_TIME - 1);
  localparam logic [15:0]      WAIT_LAST = 16'(WAIT_TIMEOUT_US - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DT_PRE    = 3'd1,
    S_WAIT_BD   = 3'd2,
    S_DISCHARGE = 3'd3,
    S_DT_POST   = 3'd4,
    S_DEION     = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             running_q, running_d;
  logic             one_shot_q, one_shot_d;
  logic             single_prev_q, single_prev_d;
  logic [15:0]      ton_q, ton_d;
  logic [15:0]      toff_q, toff_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [15:0]      us_q, us_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             pulse_on_q, pulse_on_d;
  logic             deion_on_q, deion_on_d;
  logic             will_q, will_d;
  logic             open_q, open_d;
  logic             done_q, done_d;

  logic single_rise;
  logic us_end;
  logic dead_end;
  logic ton_end;
  logic toff_end;
  logic wait_end;

  assign single_rise = bus.single_req & ~single_prev_q;
  assign us_end      = (pre_q == PRE_LAST);
  assign dead_end    = (pre_q == DEAD_LAST);
  assign ton_end     = us_end && (us_q == 16'(ton_q - 16'd1));
  assign toff_end    = us_end && (us_q == 16'(toff_q - 16'd1));
  assign wait_end    = us_end && (us_q == WAIT_LAST);

  // Next-state, timebase, config latch and registered-output decode
  always_comb begin
    state_d       = state_q;
    running_d     = running_q;
    one_shot_d    = one_shot_q;
    single_prev_d = bus.single_req;
    ton_d         = ton_q;
    toff_d        = toff_q;
    cnt_d         = cnt_q;
    open_d        = 1'b0;
    done_d        = 1'b0;

    // Stop has priority over a coincident start
    if (bus.machine_stop)       running_d = 1'b0;
    else if (bus.machine_start) running_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (running_d) begin
          if (!bus.cfg_single) begin
            state_d = S_DT_PRE;
          end else if (single_rise) begin
            state_d    = S_DT_PRE;
            one_shot_d = 1'b1;
          end
        end
      end
      S_DT_PRE: begin
        if (bus.machine_stop) state_d = S_IDLE;
        else if (dead_end)    state_d = S_WAIT_BD;
      end
      S_WAIT_BD: begin
        // stop beats breakdown, breakdown beats timeout
        if (bus.machine_stop) begin
          state_d = S_DT_POST;
        end else if (bus.is_breakdown) begin
          state_d = S_DISCHARGE;
        end else if (wait_end) begin
          state_d = S_DT_POST;
          open_d  = 1'b1;
        end
      end
      S_DISCHARGE: begin
        // an aborted discharge is not counted
        if (bus.machine_stop) begin
          state_d = S_DT_POST;
        end else if (ton_end) begin
          state_d = S_DT_POST;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_DT_POST: begin
        if (dead_end) state_d = S_DEION;
      end
      S_DEION: begin
        if (toff_end) begin
          done_d = 1'b1;
          if (running_d && !bus.cfg_single && !one_shot_q) state_d = S_DT_PRE;
          else                                             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) one_shot_d = 1'b0;

    // Ton/Toff are sampled once per cycle so mid-cycle edits cannot glitch a pulse
    if ((state_d == S_DT_PRE) && (state_q != S_DT_PRE)) begin
      ton_d  = (bus.cfg_ton_us  == 16'd0) ? 16'd1 : bus.cfg_ton_us;
      toff_d = (bus.cfg_toff_us == 16'd0) ? 16'd1 : bus.cfg_toff_us;
    end

    // Timebase restarts at every state entry
    if (state_d != state_q) begin
      pre_d = '0;
      us_d  = 16'd0;
    end else if (us_end) begin
      pre_d = '0;
      us_d  = us_q + 16'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
      us_d  = us_q;
    end

    // Outputs decoded from the next state so they switch with the state register
    pulse_on_d = (state_d == S_WAIT_BD) || (state_d == S_DISCHARGE);
    deion_on_d = (state_d == S_DEION);
    will_d     = running_d && bus.cfg_single && (state_d == S_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      running_q     <= 1'b0;
      one_shot_q    <= 1'b0;
      single_prev_q <= 1'b0;
      ton_q         <= 16'd1;
      toff_q        <= 16'd1;
      pre_q         <= '0;
      us_q          <= 16'd0;
      cnt_q         <= 16'd0;
      pulse_on_q    <= 1'b0;
      deion_on_q    <= 1'b0;
      will_q        <= 1'b0;
      open_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      one_shot_q    <= one_shot_d;
      single_prev_q <= single_prev_d;
      ton_q         <= ton_d;
      toff_q        <= toff_d;
      pre_q         <= pre_d;
      us_q          <= us_d;
      cnt_q         <= cnt_d;
      pulse_on_q    <= pulse_on_d;
      deion_on_q    <= deion_on_d;
      will_q        <= will_d;
      open_q        <= open_d;
      done_q        <= done_d;
    end
  end

  assign bus.pulse_on                        = pulse_on_q;
  assign bus.deion_on                        = deion_on_q;
  assign bus.operation_indicator             = running_q;
  assign bus.will_single_discharge_indicator = will_q;
  assign bus.open_circuit                    = open_q;
  assign bus.cycle_done                      = done_q;
  assign bus.discharge_cnt                   = cnt_q;
  assign bus.state                           = state_q;

endmodule

`default_nettype wire

// File: tb/tb_discharge_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_discharge_sequencer
// Brief    : Directed self-checking bench for discharge_sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_discharge_sequencer;

  logic clk_in;
  logic sys_rst_n;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   hi;

  discharge_sequencer_if bus ();

  discharge_sequencer #(
    .CLK_PER_US      (50),
    .DEAD_TIME       (10),
    .WAIT_TIMEOUT_US (1000)
  ) dut (
    .clk_in    (clk_in),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Advance one clock and land 1 time unit after the active edge
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus.machine_start = 1'b0;
    bus.machine_stop  = 1'b0;
    bus.single_req    = 1'b0;
    bus.is_breakdown  = 1'b0;
    bus.cfg_single    = 1'b0;
    bus.cfg_ton_us    = 16'd100;
    bus.cfg_toff_us   = 16'd50;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.machine_start = i[0];
      bus.single_req    = i[1];
      bus.cfg_single    = i[2];
      bus.is_breakdown  = ~i[0];
      bus.cfg_ton_us    = 16'(i);
      tick();
    end
    checks++; if (bus.pulse_on !== 1'b0) begin errors++; $display("FAIL reset_pulse_on: got %0b exp 0", bus.pulse_on); end
    checks++; if (bus.deion_on !== 1'b0) begin errors++; $display("FAIL reset_deion_on: got %0b exp 0", bus.deion_on); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", bus.state); end
    checks++; if (bus.discharge_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", bus.discharge_cnt); end
    checks++; if (bus.operation_indicator !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b exp 0", bus.operation_indicator); end
    idle_inputs();
    sys_rst_n = 1'b1;
    tick();
    tick();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_release_state: got %0d exp 0", bus.state); end
  endtask

  // Ton=100, Toff=50, breakdown 1000 cycles after gap-on, Ton re-latch on next cycle
  task automatic test_continuous();
    idle_inputs();
    bus.machine_start = 1'b1;
    tick();
    bus.machine_start = 1'b0;
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL cont_start_state: got %0d exp 1", bus.state); end
    checks++; if (bus.operation_indicator !== 1'b1) begin errors++; $display("FAIL cont_running: got %0b exp 1", bus.operation_indicator); end
    n = 0;
    do begin tick(); n++; end while (!bus.pulse_on && n < 50);
    checks++; if (n != 10) begin errors++; $display("FAIL cont_start_latency: got %0d exp 10", n); end
    hi = 1;
    for (int i = 1; i < 8000; i++) begin
      bus.is_breakdown = (i == 1000);
      if (i == 3000) bus.cfg_ton_us = 16'd10;
      tick();
      if (i == 1000) begin
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL cont_bd_state: got %0d exp 3", bus.state); end
      end
      if (!bus.pulse_on) break;
      hi++;
    end
    bus.is_breakdown = 1'b0;
    checks++; if (hi != 6000) begin errors++; $display("FAIL cont_pulse_len: got %0d exp 6000", hi); end
    checks++; if (bus.discharge_cnt !== 16'd1) begin errors++; $display("FAIL cont_cnt1: got %0d exp 1", bus.discharge_cnt); end
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL cont_dtpost_state: got %0d exp 4", bus.state); end
    n = 0;
    do begin tick(); n++; end while (!bus.deion_on && !bus.pulse_on && n < 100);
    checks++; if (n != 10 || bus.pulse_on) begin errors++; $display("FAIL cont_dead_post: got %0d pulse=%0b exp 10 pulse=0", n, bus.pulse_on); end
    hi = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!bus.deion_on) break;
      hi++;
    end
    checks++; if (hi != 2500) begin errors++; $display("FAIL cont_deion_len: got %0d exp 2500", hi); end
    checks++; if (bus.cycle_done !== 1'b1) begin errors++; $display("FAIL cont_cycle_done: got %0b exp 1", bus.cycle_done); end
    n = 0;
    do begin tick(); n++; end while (!bus.pulse_on && !bus.deion_on && n < 100);
    checks++; if (n != 10 || bus.deion_on) begin errors++; $display("FAIL cont_dead_pre: got %0d deion=%0b exp 10 deion=0", n, bus.deion_on); end
    // Second pulse uses the Ton=10 written during the first discharge
    bus.is_breakdown = 1'b1;
    tick();
    bus.is_breakdown = 1'b0;
    hi = 1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (bus.state !== 3'd3) break;
      hi++;
    end
    checks++; if (hi != 500) begin errors++; $display("FAIL cont_ton_relatch: got %0d exp 500", hi); end
    checks++; if (bus.discharge_cnt !== 16'd2) begin errors++; $display("FAIL cont_cnt2: got %0d exp 2", bus.discharge_cnt); end
    // Stop during DT_POST: dead time and full Toff still complete
    bus.machine_stop = 1'b1;
    tick();
    bus.machine_stop = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.state !== 3'd0 && n < 4000);
    checks++; if (n != 2509) begin errors++; $display("FAIL cont_stop_to_idle: got %0d exp 2509", n); end
    checks++; if (bus.operation_indicator !== 1'b0) begin errors++; $display("FAIL cont_stopped: got %0b exp 0", bus.operation_indicator); end
  endtask

  // No breakdown: timeout after 50000 cycles of gap-on
  task automatic test_open_circuit();
    idle_inputs();
    bus.machine_start = 1'b1;
    tick();
    bus.machine_start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!bus.pulse_on && n < 50);
    hi = 1;
    for (int i = 0; i < 60000; i++) begin
      tick();
      if (!bus.pulse_on) break;
      hi++;
    end
    checks++; if (hi != 50000) begin errors++; $display("FAIL oc_wait_len: got %0d exp 50000", hi); end
    checks++; if (bus.open_circuit !== 1'b1) begin errors++; $display("FAIL oc_pulse: got %0b exp 1", bus.open_circuit); end
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL oc_state: got %0d exp 4", bus.state); end
    tick();
    checks++; if (bus.open_circuit !== 1'b0) begin errors++; $display("FAIL oc_pulse_width: got %0b exp 0", bus.open_circuit); end
    n = 1;
    while (!bus.deion_on && n < 100) begin tick(); n++; end
    checks++; if (n != 10) begin errors++; $display("FAIL oc_dead: got %0d exp 10", n); end
    hi = 1;
    for (int i = 1; i < 4000; i++) begin
      bus.machine_stop = (i == 1);
      tick();
      if (!bus.deion_on) break;
      hi++;
    end
    bus.machine_stop = 1'b0;
    checks++; if (hi != 2500) begin errors++; $display("FAIL oc_deion_len: got %0d exp 2500", hi); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL oc_idle: got %0d exp 0", bus.state); end
    checks++; if (bus.discharge_cnt !== 16'd2) begin errors++; $display("FAIL oc_cnt: got %0d exp 2", bus.discharge_cnt); end
  endtask

  // Stop 30 us into a discharge
  task automatic test_stop();
    idle_inputs();
    bus.machine_start = 1'b1;
    tick();
    bus.machine_start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!bus.pulse_on && n < 50);
    bus.is_breakdown = 1'b1;
    tick();
    bus.is_breakdown = 1'b0;
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL stop_in_discharge: got %0d exp 3", bus.state); end
    repeat (1499) tick();
    bus.machine_stop = 1'b1;
    tick();
    bus.machine_stop = 1'b0;
    checks++; if (bus.pulse_on !== 1'b0 || bus.state !== 3'd4) begin errors++; $display("FAIL stop_abort: got pulse=%0b state=%0d exp pulse=0 state=4", bus.pulse_on, bus.state); end
    checks++; if (bus.operation_indicator !== 1'b0) begin errors++; $display("FAIL stop_running: got %0b exp 0", bus.operation_indicator); end
    n = 0;
    do begin tick(); n++; end while (!bus.deion_on && n < 100);
    checks++; if (n != 10) begin errors++; $display("FAIL stop_dead: got %0d exp 10", n); end
    hi = 1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (!bus.deion_on) break;
      hi++;
    end
    checks++; if (hi != 2500) begin errors++; $display("FAIL stop_deion_len: got %0d exp 2500", hi); end
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL stop_idle: got %0d exp 0", bus.state); end
    checks++; if (bus.discharge_cnt !== 16'd2) begin errors++; $display("FAIL stop_cnt: got %0d exp 2", bus.discharge_cnt); end
  endtask

  // Stop and breakdown in the same cycle: stop wins
  task automatic test_stop_vs_breakdown();
    idle_inputs();
    bus.machine_start = 1'b1;
    tick();
    bus.machine_start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!bus.pulse_on && n < 50);
    bus.machine_stop = 1'b1;
    bus.is_breakdown = 1'b1;
    tick();
    bus.machine_stop = 1'b0;
    bus.is_breakdown = 1'b0;
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL svb_state: got %0d exp 4", bus.state); end
    n = 0;
    do begin tick(); n++; end while (bus.state !== 3'd0 && n < 4000);
    checks++; if (n != 2510) begin errors++; $display("FAIL svb_to_idle: got %0d exp 2510", n); end
  endtask

  // Single mode with a short Ton/Toff and breakdown held so each cycle is ~221 clocks
  task automatic test_single();
    idle_inputs();
    bus.cfg_single   = 1'b1;
    bus.cfg_ton_us   = 16'd2;
    bus.cfg_toff_us  = 16'd2;
    bus.is_breakdown = 1'b1;
    bus.machine_start = 1'b1;
    tick();
    bus.machine_start = 1'b0;
    checks++; if (bus.state !== 3'd0 || bus.will_single_discharge_indicator !== 1'b1) begin errors++; $display("FAIL single_armed: got state=%0d ind=%0b exp state=0 ind=1", bus.state, bus.will_single_discharge_indicator); end
    bus.single_req = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd1 || bus.will_single_discharge_indicator !== 1'b0) begin errors++; $display("FAIL single_trigger1: got state=%0d ind=%0b exp state=1 ind=0", bus.state, bus.will_single_discharge_indicator); end
    repeat (1000) tick();
    checks++; if (bus.discharge_cnt !== 16'd3 || bus.state !== 3'd0) begin errors++; $display("FAIL single_held: got cnt=%0d state=%0d exp cnt=3 state=0", bus.discharge_cnt, bus.state); end
    checks++; if (bus.will_single_discharge_indicator !== 1'b1) begin errors++; $display("FAIL single_rearm1: got %0b exp 1", bus.will_single_discharge_indicator); end
    bus.single_req = 1'b0;
    repeat (2000) tick();
    checks++; if (bus.discharge_cnt !== 16'd3 || bus.state !== 3'd0) begin errors++; $display("FAIL single_released: got cnt=%0d state=%0d exp cnt=3 state=0", bus.discharge_cnt, bus.state); end
    bus.single_req = 1'b1;
    tick();
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL single_trigger2: got %0d exp 1", bus.state); end
    repeat (1000) tick();
    checks++; if (bus.discharge_cnt !== 16'd4 || bus.state !== 3'd0) begin errors++; $display("FAIL single_second: got cnt=%0d state=%0d exp cnt=4 state=0", bus.discharge_cnt, bus.state); end
    bus.single_req   = 1'b0;
    bus.is_breakdown = 1'b0;
    bus.machine_stop = 1'b1;
    tick();
    bus.machine_stop = 1'b0;
    checks++; if (bus.operation_indicator !== 1'b0 || bus.will_single_discharge_indicator !== 1'b0) begin errors++; $display("FAIL single_stop: got run=%0b ind=%0b exp 0 0", bus.operation_indicator, bus.will_single_discharge_indicator); end
  endtask

  // Reset asserted between clock edges during a discharge
  task automatic test_async_reset();
    idle_inputs();
    bus.machine_start = 1'b1;
    tick();
    bus.machine_start = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!bus.pulse_on && n < 50);
    bus.is_breakdown = 1'b1;
    tick();
    bus.is_breakdown = 1'b0;
    repeat (100) tick();
    checks++; if (bus.pulse_on !== 1'b1 || bus.state !== 3'd3) begin errors++; $display("FAIL arst_pre: got pulse=%0b state=%0d exp 1 3", bus.pulse_on, bus.state); end
    #3;
    sys_rst_n = 1'b0;
    #1;
    checks++; if (bus.pulse_on !== 1'b0 || bus.state !== 3'd0) begin errors++; $display("FAIL arst_drop: got pulse=%0b state=%0d exp 0 0", bus.pulse_on, bus.state); end
    checks++; if (bus.discharge_cnt !== 16'd0 || bus.operation_indicator !== 1'b0) begin errors++; $display("FAIL arst_clear: got cnt=%0d run=%0b exp 0 0", bus.discharge_cnt, bus.operation_indicator); end
    tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    idle_inputs();
    sys_rst_n = 1'b0;
    test_reset();
    test_continuous();
    test_open_circuit();
    test_stop();
    test_stop_vs_breakdown();
    test_single();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
